// File: rtl/laser_scan_sched.sv
`default_nettype none
// ============================================================================
// Module  : laser_scan_sched
// Brief   : Raster-scan sequencer for the two-laser coverage search. Finds C1,
//           then C2 with C1 fixed, then alternately refines C1/C2 until the
//           union count stops improving.
// Revision: 1.0 - initial release
// ============================================================================
module laser_scan_sched #(
   parameter int GRID_MAX = 15,
   parameter int CNT_W    = 6,
   parameter int MAX_ITER = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             start,
   output logic             cand_valid,
   input  logic             cand_ready,
   output logic [3:0]       cand_x,
   output logic [3:0]       cand_y,
   output logic             fix_en,
   output logic [3:0]       fix_x,
   output logic [3:0]       fix_y,
   input  logic             res_valid,
   input  logic [CNT_W-1:0] res_cnt,
   output logic             busy,
   output logic [3:0]       C1X,
   output logic [3:0]       C1Y,
   output logic [3:0]       C2X,
   output logic [3:0]       C2Y,
   output logic             DONE
);

   localparam int              c_IW        = (MAX_ITER < 1) ? 1 : $clog2(MAX_ITER + 1);
   localparam logic [3:0]      c_GMAX      = 4'(GRID_MAX);
   localparam logic [c_IW-1:0] c_ITER_LAST = c_IW'(MAX_ITER);

   localparam logic [2:0] c_ST_IDLE = 3'd0;
   localparam logic [2:0] c_ST_S1   = 3'd1;
   localparam logic [2:0] c_ST_S2   = 3'd2;
   localparam logic [2:0] c_ST_R1   = 3'd3;
   localparam logic [2:0] c_ST_R2   = 3'd4;
   localparam logic [2:0] c_ST_CHK  = 3'd5;
   localparam logic [2:0] c_ST_OUT  = 3'd6;

   logic [2:0]       r_state;
   logic             r_wait;
   logic [3:0]       r_x;
   logic [3:0]       r_y;
   logic [CNT_W-1:0] r_best_cnt;
   logic [3:0]       r_best_x;
   logic [3:0]       r_best_y;
   logic [3:0]       r_c1x;
   logic [3:0]       r_c1y;
   logic [3:0]       r_c2x;
   logic [3:0]       r_c2y;
   logic [CNT_W-1:0] r_total;
   logic [3:0]       r_t1x;
   logic [3:0]       r_t1y;
   logic [3:0]       r_t2x;
   logic [3:0]       r_t2y;
   logic [CNT_W-1:0] r_t2cnt;
   logic [c_IW-1:0]  r_iter;
   logic [3:0]       r_out_c1x;
   logic [3:0]       r_out_c1y;
   logic [3:0]       r_out_c2x;
   logic [3:0]       r_out_c2y;

   logic             w_scan;
   logic             w_first;
   logic             w_take;
   logic             w_last;
   logic [3:0]       w_bx;
   logic [3:0]       w_by;
   logic [CNT_W-1:0] w_bcnt;
   logic [c_IW-1:0]  w_iter_nx;

   // Best-so-far including the result arriving this cycle; (0,0) always seeds.
   always_comb begin
      w_scan    = (r_state == c_ST_S1) || (r_state == c_ST_S2) ||
                  (r_state == c_ST_R1) || (r_state == c_ST_R2);
      w_first   = (r_x == 4'd0) && (r_y == 4'd0);
      w_take    = w_first || (res_cnt > r_best_cnt);
      w_last    = (r_x == c_GMAX) && (r_y == c_GMAX);
      w_bx      = w_take ? r_x     : r_best_x;
      w_by      = w_take ? r_y     : r_best_y;
      w_bcnt    = w_take ? res_cnt : r_best_cnt;
      w_iter_nx = r_iter + c_IW'(1);
   end

   always_comb begin
      fix_en = 1'b0;
      fix_x  = 4'd0;
      fix_y  = 4'd0;
      case (r_state)
         c_ST_S2: begin
            fix_en = 1'b1;
            fix_x  = r_c1x;
            fix_y  = r_c1y;
         end
         c_ST_R1: begin
            fix_en = 1'b1;
            fix_x  = r_c2x;
            fix_y  = r_c2y;
         end
         c_ST_R2: begin
            fix_en = 1'b1;
            fix_x  = r_t1x;
            fix_y  = r_t1y;
         end
         default: begin
            fix_en = 1'b0;
         end
      endcase
   end

   assign cand_valid = w_scan && !r_wait;
   assign cand_x     = r_x;
   assign cand_y     = r_y;
   assign busy       = (r_state != c_ST_IDLE) && (r_state != c_ST_OUT);
   assign DONE       = (r_state == c_ST_OUT);
   assign C1X        = r_out_c1x;
   assign C1Y        = r_out_c1y;
   assign C2X        = r_out_c2x;
   assign C2Y        = r_out_c2y;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= c_ST_IDLE;
         r_wait     <= 1'b0;
         r_x        <= 4'd0;
         r_y        <= 4'd0;
         r_best_cnt <= '0;
         r_best_x   <= 4'd0;
         r_best_y   <= 4'd0;
         r_c1x      <= 4'd0;
         r_c1y      <= 4'd0;
         r_c2x      <= 4'd0;
         r_c2y      <= 4'd0;
         r_total    <= '0;
         r_t1x      <= 4'd0;
         r_t1y      <= 4'd0;
         r_t2x      <= 4'd0;
         r_t2y      <= 4'd0;
         r_t2cnt    <= '0;
         r_iter     <= '0;
         r_out_c1x  <= 4'd0;
         r_out_c1y  <= 4'd0;
         r_out_c2x  <= 4'd0;
         r_out_c2y  <= 4'd0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (start) begin
                  r_state   <= c_ST_S1;
                  r_wait    <= 1'b0;
                  r_x       <= 4'd0;
                  r_y       <= 4'd0;
                  r_iter    <= '0;
                  r_total   <= '0;
                  r_out_c1x <= 4'd0;
                  r_out_c1y <= 4'd0;
                  r_out_c2x <= 4'd0;
                  r_out_c2y <= 4'd0;
               end
            end
            c_ST_S1, c_ST_S2, c_ST_R1, c_ST_R2: begin
               if (!r_wait) begin
                  if (cand_ready) begin
                     r_wait <= 1'b1;
                  end
               end else if (res_valid) begin
                  r_wait     <= 1'b0;
                  r_best_cnt <= w_bcnt;
                  r_best_x   <= w_bx;
                  r_best_y   <= w_by;
                  if (w_last) begin
                     r_x <= 4'd0;
                     r_y <= 4'd0;
                     case (r_state)
                        c_ST_S1: begin
                           r_c1x   <= w_bx;
                           r_c1y   <= w_by;
                           r_state <= c_ST_S2;
                        end
                        c_ST_S2: begin
                           r_c2x   <= w_bx;
                           r_c2y   <= w_by;
                           r_total <= w_bcnt;
                           r_state <= c_ST_R1;
                        end
                        c_ST_R1: begin
                           r_t1x   <= w_bx;
                           r_t1y   <= w_by;
                           r_state <= c_ST_R2;
                        end
                        c_ST_R2: begin
                           r_t2x   <= w_bx;
                           r_t2y   <= w_by;
                           r_t2cnt <= w_bcnt;
                           r_state <= c_ST_CHK;
                        end
                        default: begin
                           r_state <= c_ST_IDLE;
                        end
                     endcase
                  end else if (r_x == c_GMAX) begin
                     r_x <= 4'd0;
                     r_y <= r_y + 4'd1;
                  end else begin
                     r_x <= r_x + 4'd1;
                  end
               end
            end
            c_ST_CHK: begin
               // Only a strict improvement of the union commits the refined pair.
               if (r_t2cnt > r_total) begin
                  r_c1x   <= r_t1x;
                  r_c1y   <= r_t1y;
                  r_c2x   <= r_t2x;
                  r_c2y   <= r_t2y;
                  r_total <= r_t2cnt;
                  r_iter  <= w_iter_nx;
                  if (w_iter_nx == c_ITER_LAST) begin
                     r_state   <= c_ST_OUT;
                     r_out_c1x <= r_t1x;
                     r_out_c1y <= r_t1y;
                     r_out_c2x <= r_t2x;
                     r_out_c2y <= r_t2y;
                  end else begin
                     r_state <= c_ST_R1;
                  end
               end else begin
                  r_state   <= c_ST_OUT;
                  r_out_c1x <= r_c1x;
                  r_out_c1y <= r_c1y;
                  r_out_c2x <= r_c2x;
                  r_out_c2y <= r_c2y;
               end
            end
            c_ST_OUT: begin
               r_state <= c_ST_IDLE;
            end
            default: begin
               r_state <= c_ST_IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_laser_scan_sched.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module  : tb_laser_scan_sched
// Brief   : Self-checking bench with a geometric coverage-engine model and a
//           high-level search reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_laser_scan_sched;
   localparam int MAX_ITER = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       start = 1'b0;
   logic       cand_valid;
   logic       cand_ready = 1'b1;
   logic [3:0] cand_x;
   logic [3:0] cand_y;
   logic       fix_en;
   logic [3:0] fix_x;
   logic [3:0] fix_y;
   logic       res_valid = 1'b0;
   logic [5:0] res_cnt = 6'd0;
   logic       busy;
   logic [3:0] C1X;
   logic [3:0] C1Y;
   logic [3:0] C2X;
   logic [3:0] C2Y;
   logic       DONE;

   laser_scan_sched #(.GRID_MAX(15), .CNT_W(6), .MAX_ITER(MAX_ITER)) dut (
      .CLK(CLK), .RST(RST), .start(start),
      .cand_valid(cand_valid), .cand_ready(cand_ready),
      .cand_x(cand_x), .cand_y(cand_y),
      .fix_en(fix_en), .fix_x(fix_x), .fix_y(fix_y),
      .res_valid(res_valid), .res_cnt(res_cnt),
      .busy(busy), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y), .DONE(DONE)
   );

   initial forever #5 CLK = ~CLK;

   int px[40];
   int py[40];
   bit force_mode = 0;
   bit rand_ready = 0;
   bit spur_en = 0;
   bit spur_now = 0;
   int acc_idx = 0;
   int res_idx = 0;
   int order_err = 0;
   int stall_at = -1;
   int stall_left = 0;
   int stall_err = 0;
   bit stall_done = 0;
   bit have_res = 0;
   int lat = 0;
   int pend_cnt = 0;
   int sx = 0;
   int sy = 0;
   int n_checks = 0;
   int n_pass = 0;
   int got_c1x, got_c1y, got_c2x, got_c2y;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic bit covers(int cx, int cy, int i);
      int dx = cx - px[i];
      int dy = cy - py[i];
      return (dx * dx + dy * dy) <= 16;
   endfunction

   function automatic int geo_count(int cx, int cy, bit fe, int fx, int fy);
      int n = 0;
      for (int i = 0; i < 40; i++)
         if (covers(cx, cy, i) || (fe && covers(fx, fy, i))) n++;
      return n;
   endfunction

   // In forced mode every result of pass p reports p, so each refinement improves.
   function automatic int ref_count(int phase, int cx, int cy, bit fe, int fx, int fy);
      return force_mode ? phase : geo_count(cx, cy, fe, fx, fy);
   endfunction

   task automatic best_scan(input int phase, input bit fe, input int fx, input int fy,
                            output int bx, output int by, output int bc);
      bc = -1; bx = 0; by = 0;
      for (int y = 0; y < 16; y++)
         for (int x = 0; x < 16; x++) begin
            int c;
            c = ref_count(phase, x, y, fe, fx, fy);
            if (c > bc) begin bc = c; bx = x; by = y; end
         end
   endtask

   task automatic model_run(output int c1x, output int c1y, output int c2x, output int c2y,
                            output int rounds);
      int total, t1x, t1y, t2x, t2y, t2c, d, ph, iter;
      best_scan(0, 0, 0, 0, c1x, c1y, d);
      best_scan(1, 1, c1x, c1y, c2x, c2y, total);
      ph = 2; rounds = 0; iter = 0;
      forever begin
         best_scan(ph, 1, c2x, c2y, t1x, t1y, d);
         best_scan(ph + 1, 1, t1x, t1y, t2x, t2y, t2c);
         ph += 2; rounds++;
         if (t2c <= total) break;
         c1x = t1x; c1y = t1y; c2x = t2x; c2y = t2y; total = t2c; iter++;
         if (iter == MAX_ITER) break;
      end
   endtask

   // Coverage engine: one outstanding candidate, 0..3 cycles extra latency.
   initial forever begin
      @(negedge CLK);
      res_valid = 1'b0;
      if (have_res) begin
         if (lat == 0) begin
            res_valid = 1'b1;
            res_cnt   = force_mode ? 6'(res_idx / 256) : 6'(pend_cnt);
            res_idx++;
            have_res  = 0;
         end else lat--;
      end else if (spur_now) begin
         res_valid = 1'b1; res_cnt = 6'h3f; spur_now = 0;
      end else if (spur_en && cand_valid && $urandom_range(0, 3) == 0) begin
         res_valid = 1'b1; res_cnt = 6'h3f;
      end
      if (stall_left == 0 && !stall_done && cand_valid && acc_idx == stall_at) begin
         stall_left = 50; sx = cand_x; sy = cand_y; stall_done = 1;
      end
      if (stall_left > 0) begin
         if (!(cand_valid && cand_x == 4'(sx) && cand_y == 4'(sy))) stall_err++;
         stall_left--;
         cand_ready = 1'b0;
      end else cand_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (cand_valid && cand_ready && !RST) begin
         if (cand_x != 4'(acc_idx % 16) || cand_y != 4'((acc_idx / 16) % 16)) order_err++;
         pend_cnt = geo_count(cand_x, cand_y, fix_en, fix_x, fix_y);
         have_res = 1;
         lat = $urandom_range(0, 3);
         acc_idx++;
      end
   end

   task automatic run_search(input string tag, input bit start_mid, input bit start_out);
      int e1x, e1y, e2x, e2y, rounds, cyc;
      bit got;
      model_run(e1x, e1y, e2x, e2y, rounds);
      acc_idx = 0; res_idx = 0; order_err = 0;
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk({tag, " busy after start"}, busy, 1);
      chk({tag, " C outs zero while busy"}, {C1X, C1Y, C2X, C2Y}, 0);
      got = 0; cyc = 0;
      while (!got && cyc < 30000) begin
         @(negedge CLK);
         cyc++;
         start = (start_mid && cyc == 200);
         if (DONE) got = 1;
      end
      start = 1'b0;
      chk({tag, " DONE seen"}, got, 1);
      got_c1x = C1X; got_c1y = C1Y; got_c2x = C2X; got_c2y = C2Y;
      chk({tag, " C1X"}, C1X, e1x);
      chk({tag, " C1Y"}, C1Y, e1y);
      chk({tag, " C2X"}, C2X, e2x);
      chk({tag, " C2Y"}, C2Y, e2y);
      chk({tag, " busy in OUT"}, busy, 0);
      if (start_out) start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk({tag, " DONE one cycle"}, DONE, 0);
      chk({tag, " C outs hold"}, {C1X, C1Y, C2X, C2Y}, {4'(e1x), 4'(e1y), 4'(e2x), 4'(e2y)});
      chk({tag, " accepted count"}, acc_idx, 256 * (2 + 2 * rounds));
      chk({tag, " raster order errors"}, order_err, 0);
      @(negedge CLK);
      chk({tag, " idle after OUT"}, busy, 0);
   endtask

   task automatic rand_points();
      for (int i = 0; i < 40; i++) begin
         px[i] = $urandom_range(0, 15);
         py[i] = $urandom_range(0, 15);
      end
   endtask

   initial begin
      int cyc;
      repeat (3) @(negedge CLK);
      chk("reset ctl", {cand_valid, fix_en, busy, DONE}, 0);
      chk("reset coords", {cand_x, cand_y, fix_x, fix_y}, 0);
      chk("reset C outs", {C1X, C1Y, C2X, C2Y}, 0);
      RST = 1'b0;
      @(negedge CLK);

      // Single cluster at (3,3)
      for (int i = 0; i < 40; i++) begin px[i] = 3; py[i] = 3; end
      run_search("t1", 0, 0);
      chk("t1 C1 is (1,0)", got_c1x * 16 + got_c1y, 32'h10);
      chk("t1 C2 is (0,0)", got_c2x * 16 + got_c2y, 0);

      // Two clusters, random ready
      for (int i = 0; i < 40; i++) begin
         px[i] = (i < 20) ? 2 : 12; py[i] = (i < 20) ? 2 : 12;
      end
      rand_ready = 1;
      run_search("t2", 0, 0);
      chk("t2 C1 is (0,0)", got_c1x * 16 + got_c1y, 0);
      chk("t2 union", geo_count(got_c1x, got_c1y, 1, got_c2x, got_c2y), 40);

      // 50-cycle engine stall mid-S2
      rand_points();
      stall_at = 300; stall_done = 0; stall_err = 0;
      run_search("t3", 0, 0);
      chk("t3 stall applied", stall_done, 1);
      chk("t3 stall candidate stable", stall_err, 0);
      stall_at = -1;

      // Spurious results in IDLE and ISSUE, start while busy and in OUT
      rand_points();
      spur_now = 1;
      repeat (3) @(negedge CLK);
      spur_en = 1;
      run_search("t4", 1, 1);
      spur_en = 0;

      // Reset during R1, then a clean rerun
      rand_points();
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      acc_idx = 0;
      cyc = 0;
      while (acc_idx < 600 && cyc < 20000) begin @(negedge CLK); cyc++; end
      chk("t5 reached R1", acc_idx >= 600, 1);
      RST = 1'b1;
      #1;
      chk("t5 reset ctl", {cand_valid, fix_en, busy, DONE}, 0);
      chk("t5 reset coords", {cand_x, cand_y, fix_x, fix_y}, 0);
      chk("t5 reset C outs", {C1X, C1Y, C2X, C2Y}, 0);
      @(negedge CLK);
      RST = 1'b0;
      repeat (6) @(negedge CLK);
      run_search("t5", 0, 0);

      // Refinement that improves every round
      force_mode = 1; rand_ready = 0;
      run_search("t6", 0, 0);
      chk("t6 accepted = 256*(2+2*MAX_ITER)", acc_idx, 256 * (2 + 2 * MAX_ITER));
      force_mode = 0;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
